// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: FSM state type and slice-count helper shared by the sequential adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int slices(input int n, input int w);
        return n / w;
    endfunction

endpackage

// File: rtl/seq_adder_if.sv
// seq_adder_if: operand/result handshake bundle; the adder sits on the slave side.
interface seq_adder_if #(parameter int N = 32);

    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic         sub;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;

    modport master (
        output s_valid, A, B, ci, sub, m_ready,
        input  s_ready, m_valid, S, co, ovf
    );

    modport slave (
        input  s_valid, A, B, ci, sub, m_ready,
        output s_ready, m_valid, S, co, ovf
    );

endinterface

// File: rtl/seq_adder_slice_adder.sv
// slice_adder: W-bit combinational adder with carry in and carry out.
module slice_adder #(parameter int W = 8) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/seq_adder.sv
// seq_adder: N-bit signed add/subtract computed W bits per cycle through one shared slice adder.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic clk,
    input  logic rstn,
    seq_adder_if.slave bus
);

    localparam int NS = slices(N, W);
    localparam int KW = $clog2(NS);

    if (N % W != 0 || N / W < 2) begin : g_bad_params
        $error("seq_adder: N must be a multiple of W with N/W >= 2");
    end

    state_t        state, nxt;
    logic [N-1:0]  a, b, s;
    logic          c, sb, co, ovf;
    logic [KW-1:0] k;
    logic [W-1:0]  sum;
    logic          cout, last;

    slice_adder #(.W(W)) u_slice (
        .a   (a[W*int'(k) +: W]),
        .b   (b[W*int'(k) +: W]),
        .ci  (c),
        .sum (sum),
        .co  (cout)
    );

    assign last = k == KW'(NS - 1);

    always_ff @(posedge clk)
        state <= rstn ? nxt : IDLE;

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (bus.s_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (bus.m_ready ? IDLE : DONE);
    end

    // Subtraction is folded into the operands at acceptance so RUN only ever adds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k   <= '0;
            s   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && bus.s_valid) begin
            a  <= bus.A;
            b  <= bus.sub ? ~bus.B : bus.B;
            c  <= bus.sub ? ~bus.ci : bus.ci;
            sb <= bus.sub;
            k  <= '0;
        end else if (state == RUN) begin
            s[W*int'(k) +: W] <= sum;
            c <= cout;
            k <= k + KW'(1);
            if (last) begin
                co  <= sb ? ~cout : cout;
                ovf <= (a[N-1] == b[N-1]) && (sum[W-1] != a[N-1]);
            end
        end
    end

    assign bus.s_ready = rstn && state == IDLE;
    assign bus.m_valid = state == DONE;
    assign bus.S       = s;
    assign bus.co      = co;
    assign bus.ovf     = ovf;

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: scoreboard bench for seq_adder with N=32, W=8.
module tb_seq_adder;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seq_adder_if #(.N(32)) bus ();

    seq_adder #(.N(32), .W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } res_t;

    res_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
        logic [31:0] eb;
        logic [32:0] r;
        res_t        x;
        eb    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, eb} + {32'd0, sub ? ~ci : ci};
        x.s   = r[31:0];
        x.co  = sub ? ~r[32] : r[32];
        x.ovf = (a[31] == eb[31]) && (r[31] != a[31]);
        return x;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                         input res_t e, input int hold);
        int   t;
        int   lat;
        res_t x;
        t = 0;
        @(negedge clk);
        while (!bus.s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("s_ready_idle", 64'(bus.s_ready), 64'd1);
        bus.A = a;
        bus.B = b;
        bus.ci = ci;
        bus.sub = sub;
        bus.s_valid = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.ci = 1'($urandom);
        bus.sub = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.m_valid && lat < 20);
        check("latency", 64'(lat), 64'd4);
        check("s_ready_busy", 64'(bus.s_ready), 64'd0);
        x = sbq.pop_front();
        check("S", 64'(bus.S), 64'(x.s));
        check("co", 64'(bus.co), 64'(x.co));
        check("ovf", 64'(bus.ovf), 64'(x.ovf));
        for (int i = 0; i < hold; i++) begin
            bus.s_valid = 1'b1;
            bus.A = $urandom;
            bus.m_ready = 1'b0;
            @(posedge clk);
            #1;
            check("hold_S", 64'(bus.S), 64'(x.s));
            check("hold_co", 64'(bus.co), 64'(x.co));
            check("hold_ovf", 64'(bus.ovf), 64'(x.ovf));
            check("hold_s_ready", 64'(bus.s_ready), 64'd0);
            check("hold_m_valid", 64'(bus.m_valid), 64'd1);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        check("idle_s_ready", 64'(bus.s_ready), 64'd1);
        check("idle_m_valid", 64'(bus.m_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        int          mv;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.ci = 1'b0;
        bus.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_S", 64'(bus.S), 64'd0);
        check("rst_co", 64'(bus.co), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        rstn = 1'b1;
        #1;
        check("rel_s_ready", 64'(bus.s_ready), 64'd1);

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0100, 1'b0, 1'b0}, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1}, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0}, 0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b1, 1'b0}, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b0, 1'b1}, 0);
        do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, {32'h2143_6588, 1'b0, 1'b0}, 3);

        // Abort mid-run: reset lands after two slices have been written.
        @(negedge clk);
        bus.A = 32'h1111_1111;
        bus.B = 32'h2222_2222;
        bus.ci = 1'b0;
        bus.sub = 1'b0;
        bus.s_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_s_ready_low", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        check("abort_S", 64'(bus.S), 64'd0);
        check("abort_co", 64'(bus.co), 64'd0);
        check("abort_ovf", 64'(bus.ovf), 64'd0);
        check("abort_m_valid", 64'(bus.m_valid), 64'd0);
        rstn = 1'b1;
        #1;
        check("abort_s_ready", 64'(bus.s_ready), 64'd1);
        mv = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            mv += int'(bus.m_valid);
        end
        check("abort_no_m_valid", 64'(mv), 64'd0);
        do_op(32'd1, 32'd1, 1'b0, 1'b0, {32'd2, 1'b0, 1'b0}, 0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            rs = 1'($urandom);
            do_op(ra, rb, rc, rs, model(ra, rb, rc, rs), i % 3);
        end

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter N, default 32: total operand/result width in bits.
REQ-002 Parameter W, default 8: slice width added per cycle; N SHALL be an integer multiple of W, with N/W >= 2.
REQ-003 Ports:
- clk  input  1  single clock, all state on rising edge.
- rstn  input  1  synchronous, active-low reset.
- s_valid  input  1  operand set valid.
- s_ready  output  1  block can accept operands.
- A  input  N  signed operand A.
- B  input  N  signed operand B.
- ci  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  mode: 0 = A+B+ci, 1 = A-B-ci.
- m_valid  output  1  result valid.
- m_ready  input  1  consumer accepts result.
- S  output  N  signed result.
- co  output  1  carry-out (add) or borrow-out (subtract).
- ovf  output  1  signed two's-complement overflow.

Function
REQ-004 FSM states: IDLE, RUN, DONE; reset state is IDLE.
REQ-005 IDLE: s_ready=1, m_valid=0; when s_valid=1, latch A, B, ci and sub, clear the slice counter to 0, and go to RUN.
REQ-006 Operand preparation at acceptance: effective B = sub ? ~B : B; initial carry = sub ? ~ci : ci.
REQ-007 RUN: s_ready=0; each cycle, add slice k (bits k*W+W-1 : k*W), LSB slice first; store the sum slice; carry chains to the next cycle; k increments.
REQ-008 After slice N/W-1 completes, go to DONE; m_valid rises exactly N/W cycles after the acceptance edge (4 for the defaults).
REQ-009 co = sub ? ~final_carry : final_carry.
REQ-010 ovf = (A[N-1] == effB[N-1]) && (S[N-1] != A[N-1]), using the latched operands.
REQ-011 DONE: m_valid=1, s_ready=0; S, co and ovf SHALL stay stable until m_ready=1.
REQ-012 On m_valid && m_ready, go to IDLE; s_ready is 1 on the next cycle. There is no back-to-back overlap: minimum initiation interval is N/W+2 cycles.
REQ-013 s_valid while s_ready=0 SHALL be ignored, with no effect on the in-flight operation.
REQ-014 Inputs A, B, ci and sub changing after acceptance SHALL NOT affect the result.
REQ-015 Intermediate S contents during RUN are don't-care externally; only values qualified by m_valid are defined.

Reset
REQ-016 While rstn=0 at a clk edge: state=IDLE, slice counter=0, S=0, co=0, ovf=0, m_valid=0, and s_ready=0 while rstn is low.
REQ-017 Reset asserted in RUN or DONE SHALL abort the operation; no m_valid SHALL be produced for it.
REQ-018 s_ready=1 on the first cycle after rstn returns high.

Structure
REQ-019 Package seq_adder_pkg SHALL hold the FSM state enum type and a function computing slice count from N and W.
REQ-020 One sub-module, slice_adder: parametrised W-bit combinational adder (a, b, ci -> sum, co), instantiated once and reused every RUN cycle.
REQ-021 Elaboration SHALL fail if N % W != 0 or N/W < 2.

Verification (N=32, W=8)
REQ-022 Verify: A=0x000000FF, B=0x00000001, ci=0, sub=0 -> S=0x00000100, co=0, ovf=0, m_valid exactly 4 cycles after acceptance.
REQ-023 Verify: A=0x7FFFFFFF, B=0x00000001, add -> S=0x80000000, ovf=1, co=0; and A=0xFFFFFFFF, B=0x00000001 -> S=0x00000000, co=1, ovf=0.
REQ-024 Verify: sub=1, A=5, B=7, ci=0 -> S=0xFFFFFFFE, co=1 (borrow), ovf=0; and A=0x80000000, B=1 -> S=0x7FFFFFFF, ovf=1.
REQ-025 Verify: m_ready held 0 for 3 cycles in DONE, with s_valid=1 and a new A driven meanwhile -> S, co and ovf unchanged, s_ready=0, the new operands are not accepted, and IDLE is entered the cycle after m_ready=1.
REQ-026 Verify: rstn=0 for one cycle at RUN slice 2 -> m_valid never asserts for that operation, outputs are 0, s_ready=1 the next cycle, and a subsequent 1+1 gives S=2.
